sf_crossbar_rt: RTL and testbench
=================================

Name: sf_crossbar_rt

Overview:
- Parametrised, registered successor to the 5-port combinational switch fabric.
- Routes PORTS data channels of DATA_W bits. Each output selects one of the other PORTS-1 inputs through a one-hot config vector; the output's own input is never selectable.
- Adds a per-port valid/ready handshake, a one-cycle registered output stage, multicast backpressure, double-buffered (shadow/active) configuration with a drain-then-commit state machine, and config error flags.
- Sits between the compute tiles and the interconnect of the reconfigurable fabric.

Parameters:
- PORTS, 5, number of ports; must be 3 or more.
- DATA_W, 32, data width per port.
- Derived localparam CFG_W = PORTS-1: config vector width.
- Derived localparam PID_W = clog2(PORTS): port index width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- din  in  PORTS*DATA_W  input data; port i occupies bits [i*DATA_W +: DATA_W].
- din_valid  in  PORTS  input valid per port.
- din_ready  out  PORTS  input ready per port.
- dout  out  PORTS*DATA_W  registered output data.
- dout_valid  out  PORTS  output valid per port.
- dout_ready  in  PORTS  downstream ready per port.
- cfg_wr_en  in  1  shadow config write strobe.
- cfg_wr_port  in  PID_W  output port whose shadow vector is written.
- cfg_wr_vec  in  CFG_W  one-hot source select, or all-zero for disconnect.
- cfg_commit  in  1  request to copy shadow config into active config.
- cfg_busy  out  1  high while in DRAIN or APPLY.
- cfg_err  out  PORTS  sticky flag per output: last applied vector was not one-hot or zero.
- cfg_err_clr  in  1  clears all cfg_err bits.

Behaviour:
- Source mapping for output j: vector bit k selects input k if k<j, else input k+1.
  - Vector 0 means disconnected.
  - A vector with more than one bit set is treated as disconnected.
- Reset:
  - dout=0, dout_valid=0, cfg_err=0, cfg_busy=0.
  - Shadow and active config = 0 (all outputs disconnected).
  - State = RUN; din_ready follows the RUN rule, so all ports read 1.
  - Reset overrides everything, including mid-DRAIN or mid-APPLY.
- Shadow write: on cfg_wr_en, shadow[cfg_wr_port] <= cfg_wr_vec.
  - Accepted in any state.
  - Writes with cfg_wr_port >= PORTS are ignored.
- State machine:
  - RUN: cfg_commit=1 moves to DRAIN.
  - DRAIN: all dout_valid==0 moves to APPLY; otherwise stays in DRAIN. cfg_commit is ignored here.
  - APPLY (1 cycle): active <= shadow (including any write made in this cycle's prior edge). cfg_err[j] is set for each output with a multi-bit vector. Next state is RUN.
- Readiness:
  - din_ready = 0 in DRAIN and APPLY.
  - In RUN, din_ready[i] = AND over every output j actively selecting i of (!dout_valid[j] || dout_ready[j]).
  - An input selected by no output has din_ready=1, and its data is dropped.
- Transfer and latency:
  - A transfer occurs on din_valid[i] && din_ready[i].
  - Every output selecting i loads din[i] and sets dout_valid the next cycle. Latency is 1 cycle.
  - Multicast is atomic: all selected outputs load in the same cycle, or none do.
- Output hold:
  - Output j clears dout_valid when dout_ready[j] is high and no new load occurs.
  - dout holds its value while dout_valid=1 and dout_ready=0.
  - A simultaneous pop and load gives back-to-back throughput of 1 word per cycle per port.
- cfg_err:
  - Set by APPLY and cleared by cfg_err_clr.
  - If both occur in the same cycle, set wins.
- din_ready combinationally depends on dout_ready; this is a documented path.

Test Plan:
- Reset, din = 1..5 all valid, no config: din_ready=5'b11111; dout_valid stays 0 for 10 cycles.
- Write port0 vec 4'b0001, commit at cycle t: cfg_busy=1 at t+1 and t+2, RUN at t+3. Then dinB=2 valid gives doutA=2 with dout_valid[0]=1 one cycle later.
- Multicast B to A (0001), C (0010), D (0010), E (0010), with dout_ready[3]=0 after the first word:
  - din_ready[1]=0 while doutD is held at 2.
  - Raising dout_ready[3] restores din_ready[1].
  - The next word reaches A, C, D and E in the same cycle.
- Vector 4'b0011 written to port4 and committed: cfg_err[4]=1 after APPLY and dout_valid[4] is never asserted. Pulsing cfg_err_clr returns cfg_err to 0.
- Commit while doutC is valid with dout_ready[2]=0:
  - State stays in DRAIN and din_ready=0 for 20 cycles.
  - After dout_ready[2]=1, dout_valid[2] drops, then APPLY follows, then RUN.
- rst asserted during DRAIN with outputs holding data: the next cycle has state RUN, dout_valid=0, dout=0, active and shadow config 0, cfg_busy=0.

Source files
------------

// File: rtl/sf_crossbar_rt.sv
// sf_crossbar_rt: registered PORTS-way crossbar with valid/ready handshake,
// atomic multicast backpressure and shadow/active config committed through
// a drain-then-apply state machine.

// One output lane: decodes its active vector into a source one-hot, muxes the
// selected input and holds it in the registered output stage.
module sf_crossbar_rt_lane #(
   parameter int PORTS  = 5,
   parameter int DATA_W = 32,
   parameter int LANE   = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [PORTS-2:0]             laneVec,
   input  logic [PORTS-1:0][DATA_W-1:0] srcData,
   input  logic [PORTS-1:0]             srcValid,
   input  logic [PORTS-1:0]             srcReady,
   input  logic                         popReady,
   output logic [PORTS-1:0]             laneSel,
   output logic [DATA_W-1:0]            laneData,
   output logic                         laneValid
);
   localparam int CFG_W = PORTS - 1;

   logic              vecOneHot;
   logic              load;
   logic [DATA_W-1:0] pickData;

   // Zero or multi-bit vectors both leave the lane disconnected.
   assign vecOneHot = (laneVec != '0) && ((laneVec & (laneVec - CFG_W'(1))) == '0);

   // Vector bit k names input k below this lane and input k+1 above it.
   for (genvar i = 0; i < PORTS; i++) begin : gSel
      if (i < LANE) begin : gLo
         assign laneSel[i] = vecOneHot & laneVec[i];
      end else if (i > LANE) begin : gHi
         assign laneSel[i] = vecOneHot & laneVec[i-1];
      end else begin : gSelf
         assign laneSel[i] = 1'b0;
      end
   end

   // Pick the selected source and detect a transfer on it.
   always_comb begin
      pickData = '0;
      load     = 1'b0;
      for (int i = 0; i < PORTS; i++) begin
         if (laneSel[i]) begin
            pickData = srcData[i];
            load     = srcValid[i] & srcReady[i];
         end
      end
   end

   // Output register: a load wins over a pop so back-to-back words stream.
   always_ff @(posedge clk) begin
      if (rst) begin
         laneData  <= '0;
         laneValid <= 1'b0;
      end else if (load) begin
         laneData  <= pickData;
         laneValid <= 1'b1;
      end else if (popReady) begin
         laneValid <= 1'b0;
      end
   end
endmodule

module sf_crossbar_rt #(
   parameter  int PORTS  = 5,
   parameter  int DATA_W = 32,
   localparam int CFG_W  = PORTS - 1,
   localparam int PID_W  = $clog2(PORTS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [PORTS*DATA_W-1:0] din,
   input  logic [PORTS-1:0]        din_valid,
   output logic [PORTS-1:0]        din_ready,
   output logic [PORTS*DATA_W-1:0] dout,
   output logic [PORTS-1:0]        dout_valid,
   input  logic [PORTS-1:0]        dout_ready,
   input  logic                    cfg_wr_en,
   input  logic [PID_W-1:0]        cfg_wr_port,
   input  logic [CFG_W-1:0]        cfg_wr_vec,
   input  logic                    cfg_commit,
   output logic                    cfg_busy,
   output logic [PORTS-1:0]        cfg_err,
   input  logic                    cfg_err_clr
);
   typedef enum logic [1:0] {RUN, DRAIN, APPLY} stateT;

   localparam logic [PID_W:0] NUM_PORTS = (PID_W+1)'(PORTS);

   stateT                         state, nextState;
   logic [PORTS-1:0][CFG_W-1:0]   shadowCfg, activeCfg;
   logic [PORTS-1:0][PORTS-1:0]   selMat;
   logic [PORTS-1:0][DATA_W-1:0]  dinArr, doutArr;
   logic [PORTS-1:0]              inReady, multiBit;
   logic                          wrHit;

   assign dinArr    = din;
   assign dout      = doutArr;
   assign din_ready = inReady;
   assign cfg_busy  = (state != RUN);
   assign wrHit     = cfg_wr_en && ({1'b0, cfg_wr_port} < NUM_PORTS);

   for (genvar j = 0; j < PORTS; j++) begin : gLane
      assign multiBit[j] = (shadowCfg[j] & (shadowCfg[j] - CFG_W'(1))) != '0;

      sf_crossbar_rt_lane #(.PORTS(PORTS), .DATA_W(DATA_W), .LANE(j)) uLane (
         .clk      (clk),
         .rst      (rst),
         .laneVec  (activeCfg[j]),
         .srcData  (dinArr),
         .srcValid (din_valid),
         .srcReady (inReady),
         .popReady (dout_ready[j]),
         .laneSel  (selMat[j]),
         .laneData (doutArr[j]),
         .laneValid(dout_valid[j])
      );
   end

   // An input is ready only if every output it feeds can accept this cycle,
   // which makes multicast all-or-nothing.
   always_comb begin
      inReady = '0;
      for (int i = 0; i < PORTS; i++) begin
         inReady[i] = (state == RUN);
         for (int j = 0; j < PORTS; j++)
            if (selMat[j][i] && dout_valid[j] && !dout_ready[j]) inReady[i] = 1'b0;
      end
   end

   // Config state register.
   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= nextState;
   end

   // Commit drains every output before swapping configs.
   always_comb begin
      nextState = state;
      case (state)
         RUN:     if (cfg_commit) nextState = DRAIN;
         DRAIN:   if (dout_valid == '0) nextState = APPLY;
         APPLY:   nextState = RUN;
         default: nextState = RUN;
      endcase
   end

   // Shadow writes land in any state; APPLY copies the pre-edge shadow.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadowCfg <= '0;
         activeCfg <= '0;
      end else begin
         if (state == APPLY) activeCfg <= shadowCfg;
         if (wrHit) shadowCfg[cfg_wr_port] <= cfg_wr_vec;
      end
   end

   // Sticky error flags; a set from APPLY beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst)                 cfg_err <= '0;
      else if (state == APPLY) cfg_err <= (cfg_err_clr ? {PORTS{1'b0}} : cfg_err) | multiBit;
      else if (cfg_err_clr)    cfg_err <= '0;
   end
endmodule

// File: tb/tb_sf_crossbar_rt.sv
// tb_sf_crossbar_rt: directed test-plan steps followed by random traffic,
// every cycle compared against a per-port behavioural model.
module tb_sf_crossbar_rt;
   localparam int PORTS  = 5;
   localparam int DATA_W = 32;
   localparam int CFG_W  = PORTS - 1;
   localparam int PID_W  = $clog2(PORTS);

   logic                    clk = 1'b0;
   logic                    rst;
   logic [PORTS*DATA_W-1:0] din;
   logic [PORTS-1:0]        din_valid, din_ready;
   logic [PORTS*DATA_W-1:0] dout;
   logic [PORTS-1:0]        dout_valid, dout_ready;
   logic                    cfg_wr_en;
   logic [PID_W-1:0]        cfg_wr_port;
   logic [CFG_W-1:0]        cfg_wr_vec;
   logic                    cfg_commit, cfg_busy, cfg_err_clr;
   logic [PORTS-1:0]        cfg_err;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   sf_crossbar_rt #(.PORTS(PORTS), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .cfg_wr_en(cfg_wr_en), .cfg_wr_port(cfg_wr_port), .cfg_wr_vec(cfg_wr_vec),
      .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
      .cfg_err_clr(cfg_err_clr)
   );

   // Reference model: config vectors as integers, outputs as plain arrays,
   // phase 0 = running, 1 = draining, 2 = applying.
   int                mShadow[PORTS];
   int                mActive[PORTS];
   logic [DATA_W-1:0] mDout[PORTS];
   bit                mVal[PORTS];
   bit                mErr[PORTS];
   int                mPhase;

   function automatic int srcOf(int j, int vec);
      if ($countones(vec) != 1) return -1;
      for (int k = 0; k < CFG_W; k++)
         if (vec[k]) return (k < j) ? k : k + 1;
      return -1;
   endfunction

   function automatic logic [PORTS-1:0] expReady();
      logic [PORTS-1:0] r;
      int s;
      for (int i = 0; i < PORTS; i++) r[i] = (mPhase == 0);
      for (int j = 0; j < PORTS; j++) begin
         s = srcOf(j, mActive[j]);
         if (s >= 0 && mVal[j] && !dout_ready[j]) r[s] = 1'b0;
      end
      return r;
   endfunction

   task automatic modelReset();
      for (int j = 0; j < PORTS; j++) begin
         mShadow[j] = 0; mActive[j] = 0; mDout[j] = '0; mVal[j] = 0; mErr[j] = 0;
      end
      mPhase = 0;
   endtask

   task automatic modelEdge();
      logic [PORTS-1:0] r;
      bit anyVal;
      int s;
      if (rst) begin
         modelReset();
         return;
      end
      r = expReady();
      anyVal = 0;
      for (int j = 0; j < PORTS; j++) anyVal |= mVal[j];
      for (int j = 0; j < PORTS; j++) begin
         s = srcOf(j, mActive[j]);
         if (s >= 0 && din_valid[s] && r[s]) begin
            mDout[j] = din[s*DATA_W +: DATA_W];
            mVal[j]  = 1;
         end else if (dout_ready[j]) begin
            mVal[j] = 0;
         end
      end
      if (cfg_err_clr) for (int j = 0; j < PORTS; j++) mErr[j] = 0;
      if (mPhase == 2)
         for (int j = 0; j < PORTS; j++) begin
            if ($countones(mShadow[j]) > 1) mErr[j] = 1;
            mActive[j] = mShadow[j];
         end
      if (mPhase == 0) begin
         if (cfg_commit) mPhase = 1;
      end else if (mPhase == 1) begin
         if (!anyVal) mPhase = 2;
      end else begin
         mPhase = 0;
      end
      if (cfg_wr_en && int'(cfg_wr_port) < PORTS) mShadow[cfg_wr_port] = int'(cfg_wr_vec);
   endtask

   task automatic chkD(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin fails++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end
   endtask

   task automatic chkV(input string tag, input logic [PORTS-1:0] obs, input logic [PORTS-1:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin fails++; $error("FAIL %s: observed %b expected %b", tag, obs, exp); end
   endtask

   task automatic chkB(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) passes++;
      else begin fails++; $error("FAIL %s: observed %b expected %b", tag, obs, exp); end
   endtask

   task automatic checkAll();
      logic [PORTS-1:0] eV, eE;
      for (int j = 0; j < PORTS; j++) begin
         chkD("dout", dout[j*DATA_W +: DATA_W], mDout[j]);
         eV[j] = mVal[j];
         eE[j] = mErr[j];
      end
      chkV("dout_valid", dout_valid, eV);
      chkV("din_ready", din_ready, expReady());
      chkV("cfg_err", cfg_err, eE);
      chkB("cfg_busy", cfg_busy, mPhase != 0);
   endtask

   // One clock: compare pre-edge outputs, advance the model, cross the edge.
   task automatic cycle();
      #1;
      checkAll();
      modelEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic writeCfg(input int port, input int vec);
      cfg_wr_en   = 1'b1;
      cfg_wr_port = PID_W'(port);
      cfg_wr_vec  = CFG_W'(vec);
      cycle();
      cfg_wr_en   = 1'b0;
   endtask

   task automatic commitAndWait();
      cfg_commit = 1'b1;
      cycle();
      cfg_commit = 1'b0;
      for (int n = 0; n < 40 && cfg_busy; n++) cycle();
      chkB("commit_timeout", cfg_busy, 1'b0);
   endtask

   initial begin
      rst = 1'b1; din_valid = '0; dout_ready = '1; cfg_wr_en = 1'b0; cfg_wr_port = '0;
      cfg_wr_vec = '0; cfg_commit = 1'b0; cfg_err_clr = 1'b0;
      for (int i = 0; i < PORTS; i++) din[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
      @(posedge clk);
      #1;
      modelReset();

      // Reset state, all inputs valid with no routes.
      chkV("reset_valid", dout_valid, '0);
      chkB("reset_busy", cfg_busy, 1'b0);
      rst = 1'b0;
      din_valid = '1;
      for (int n = 0; n < 10; n++) begin
         chkV("noroute_ready", din_ready, 5'b11111);
         chkV("noroute_valid", dout_valid, '0);
         cycle();
      end

      // Route B to A; commit takes busy for two cycles.
      writeCfg(0, 4'b0001);
      cfg_commit = 1'b1;
      cycle();
      cfg_commit = 1'b0;
      chkB("busy_t1", cfg_busy, 1'b1);
      din_valid = 5'b00010;
      cycle();
      chkB("busy_t2", cfg_busy, 1'b1);
      cycle();
      chkB("busy_t3", cfg_busy, 1'b0);
      cycle();
      chkD("unicast_data", dout[0 +: DATA_W], 32'd2);
      chkB("unicast_valid", dout_valid[0], 1'b1);

      // Multicast B to A, C, D, E with D stalling.
      writeCfg(2, 4'b0010);
      writeCfg(3, 4'b0010);
      writeCfg(4, 4'b0010);
      commitAndWait();
      dout_ready = 5'b10111;
      cycle();
      din[1*DATA_W +: DATA_W] = 32'd7;
      for (int n = 0; n < 3; n++) begin
         #1;
         chkB("mc_stall_ready", din_ready[1], 1'b0);
         chkD("mc_hold_d", dout[3*DATA_W +: DATA_W], 32'd2);
         cycle();
      end
      dout_ready = '1;
      #1;
      chkB("mc_release_ready", din_ready[1], 1'b1);
      cycle();
      for (int j = 0; j < PORTS; j++)
         if (j != 1) chkD("mc_word2", dout[j*DATA_W +: DATA_W], 32'd7);
      chkV("mc_valid", dout_valid, 5'b11101);

      // Multi-bit vector on E: error flag, E never valid, clear.
      writeCfg(4, 4'b0011);
      commitAndWait();
      chkB("err_set", cfg_err[4], 1'b1);
      din_valid = '1;
      for (int n = 0; n < 5; n++) begin
         cycle();
         chkB("err_port_idle", dout_valid[4], 1'b0);
      end
      cfg_err_clr = 1'b1;
      cycle();
      cfg_err_clr = 1'b0;
      chkV("err_clr", cfg_err, '0);

      // Commit while C is stalled: drain holds until C is popped.
      din_valid = 5'b00010;
      din[1*DATA_W +: DATA_W] = 32'd9;
      dout_ready = 5'b11011;
      cycle();
      din_valid = '0;
      cfg_commit = 1'b1;
      cycle();
      cfg_commit = 1'b0;
      for (int n = 0; n < 20; n++) begin
         chkB("drain_busy", cfg_busy, 1'b1);
         chkV("drain_ready", din_ready, '0);
         cycle();
      end
      dout_ready = '1;
      cycle();
      chkB("drain_pop", dout_valid[2], 1'b0);
      chkB("drain_apply", cfg_busy, 1'b1);
      cycle();
      chkB("drain_apply2", cfg_busy, 1'b1);
      cycle();
      chkB("drain_run", cfg_busy, 1'b0);

      // Reset in the middle of a drain.
      dout_ready = '0;
      din_valid = 5'b00010;
      cycle();
      din_valid = '0;
      cfg_commit = 1'b1;
      cycle();
      cfg_commit = 1'b0;
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chkB("rst_busy", cfg_busy, 1'b0);
      chkV("rst_valid", dout_valid, '0);
      for (int j = 0; j < PORTS; j++) chkD("rst_dout", dout[j*DATA_W +: DATA_W], '0);
      chkV("rst_ready", din_ready, '1);
      dout_ready = '1;
      commitAndWait();
      din_valid = '1;
      cycle();
      cycle();
      chkV("rst_shadow_clear", dout_valid, '0);

      // Random traffic and reconfiguration.
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < PORTS; i++) din[i*DATA_W +: DATA_W] = $urandom;
         din_valid   = PORTS'($urandom);
         dout_ready  = PORTS'($urandom | $urandom);
         cfg_wr_en   = ($urandom_range(0, 5) == 0);
         cfg_wr_port = PID_W'($urandom_range(0, 7));
         cfg_wr_vec  = ($urandom_range(0, 3) == 0) ? CFG_W'($urandom_range(0, 15))
                                                   : CFG_W'(1 << $urandom_range(0, 3));
         cfg_commit  = ($urandom_range(0, 12) == 0);
         cfg_err_clr = ($urandom_range(0, 25) == 0);
         rst         = ($urandom_range(0, 250) == 0);
         cycle();
      end
      rst = 1'b0; cfg_wr_en = 1'b0; cfg_commit = 1'b0; cfg_err_clr = 1'b0;
      cycle();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
